// File: rtl/bp_burst_to_wormhole.sv
// Converts a header + data-burst stream into a wormhole packet (header flits then data flits).
// Optional header bypass: define BP_BURST_TO_WORMHOLE_HDR_BYPASS_EN to emit flit 0 in the header handshake cycle.
module bp_burst_to_wormhole #(
  parameter int unsigned flit_width_p   = 32,
  parameter int unsigned cord_width_p   = 4,
  parameter int unsigned len_width_p    = 4,
  parameter int unsigned pr_hdr_width_p = 48
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,

  input  logic [pr_hdr_width_p-1:0] pr_hdr_i,
  input  logic [cord_width_p-1:0]   dst_cord_i,
  input  logic [len_width_p-1:0]    data_flits_i,
  input  logic                      hdr_v_i,
  output logic                      hdr_ready_and_o,

  input  logic [flit_width_p-1:0]   data_i,
  input  logic                      data_v_i,
  output logic                      data_ready_and_o,

  output logic [flit_width_p-1:0]   link_data_o,
  output logic                      link_v_o,
  input  logic                      link_ready_and_i
);

  localparam int unsigned hdr_width_lp  = cord_width_p + len_width_p + pr_hdr_width_p;
  localparam int unsigned hdr_len_lp    = (hdr_width_lp + flit_width_p - 1) / flit_width_p;
  localparam int unsigned img_width_lp  = hdr_len_lp * flit_width_p;
  localparam int unsigned hcnt_width_lp = $clog2(hdr_len_lp + 1);
  localparam int unsigned idx_width_lp  = (hdr_len_lp > 1) ? $clog2(hdr_len_lp) : 1;

  localparam logic [1:0] e_ready = 2'd0;
  localparam logic [1:0] e_hdr   = 2'd1;
  localparam logic [1:0] e_data  = 2'd2;

  logic [1:0]                                state_r, state_n;
  logic [hdr_len_lp-1:0][flit_width_p-1:0]   img_r, img_n, img_c;
  logic [hcnt_width_lp-1:0]                  hcnt_r, hcnt_n;
  logic [len_width_p-1:0]                    dcnt_r, dcnt_n;
  logic [len_width_p-1:0]                    len_c;
  logic [idx_width_lp-1:0]                   hdr_idx;
  // Low during reset and for the first cycle after release; gates all handshakes.
  logic                                      live_r;

  // Header image: {pr_hdr, len, cord}, cord at the LSBs, zero-padded to whole flits.
  always_comb begin
    len_c   = len_width_p'(hdr_len_lp + 32'(data_flits_i) - 32'd1);
    img_c   = img_width_lp'({pr_hdr_i, len_c, dst_cord_i});
    hdr_idx = idx_width_lp'(hcnt_width_lp'(hdr_len_lp) - hcnt_r);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_ready;
      img_r   <= '0;
      hcnt_r  <= '0;
      dcnt_r  <= '0;
      live_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      img_r   <= img_n;
      hcnt_r  <= hcnt_n;
      dcnt_r  <= dcnt_n;
      live_r  <= 1'b1;
    end
  end

  // Next-state, counter updates and handshake outputs.
  always_comb begin
    state_n          = state_r;
    img_n            = img_r;
    hcnt_n           = hcnt_r;
    dcnt_n           = dcnt_r;
    hdr_ready_and_o  = 1'b0;
    data_ready_and_o = 1'b0;
    link_v_o         = 1'b0;
    link_data_o      = img_r[hdr_idx];

    case (state_r)
      e_ready: begin
        hdr_ready_and_o = live_r;
`ifdef BP_BURST_TO_WORMHOLE_HDR_BYPASS_EN
        link_v_o    = live_r & hdr_v_i;
        link_data_o = img_c[0];
`endif
        if (live_r && hdr_v_i) begin
          img_n   = img_c;
          dcnt_n  = data_flits_i;
          hcnt_n  = hcnt_width_lp'(hdr_len_lp);
          state_n = e_hdr;
`ifdef BP_BURST_TO_WORMHOLE_HDR_BYPASS_EN
          // Flit 0 already went out this cycle; otherwise it is replayed from the register.
          if (link_ready_and_i) begin
            hcnt_n = hcnt_width_lp'(hdr_len_lp - 1);
            if (hdr_len_lp == 1) begin
              state_n = (data_flits_i != '0) ? e_data : e_ready;
            end
          end
`endif
        end
      end

      e_hdr: begin
        link_v_o    = 1'b1;
        link_data_o = img_r[hdr_idx];
        if (link_ready_and_i) begin
          hcnt_n = hcnt_r - hcnt_width_lp'(1);
          if (hcnt_r == hcnt_width_lp'(1)) begin
            state_n = (dcnt_r != '0) ? e_data : e_ready;
          end
        end
      end

      e_data: begin
        link_v_o         = data_v_i;
        link_data_o      = data_i;
        data_ready_and_o = link_ready_and_i;
        if (data_v_i && link_ready_and_i) begin
          dcnt_n = dcnt_r - len_width_p'(1);
          if (dcnt_r == len_width_p'(1)) begin
            state_n = e_ready;
          end
        end
      end

      default: begin
        state_n = e_ready;
      end
    endcase
  end

endmodule

// File: tb/tb_bp_burst_to_wormhole.sv
// Directed bench for bp_burst_to_wormhole: table of packets with link/data stalls plus reset sequences.
module tb_bp_burst_to_wormhole;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [47:0] pr_hdr_i;
  logic [3:0]  dst_cord_i;
  logic [3:0]  data_flits_i;
  logic        hdr_v_i;
  logic        hdr_ready_and_o;
  logic [31:0] data_i;
  logic        data_v_i;
  logic        data_ready_and_o;
  logic [31:0] link_data_o;
  logic        link_v_o;
  logic        link_ready_and_i;

  always #5 clk_i = ~clk_i;

  bp_burst_to_wormhole #(
    .flit_width_p  (32),
    .cord_width_p  (4),
    .len_width_p   (4),
    .pr_hdr_width_p(48)
  ) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .pr_hdr_i        (pr_hdr_i),
    .dst_cord_i      (dst_cord_i),
    .data_flits_i    (data_flits_i),
    .hdr_v_i         (hdr_v_i),
    .hdr_ready_and_o (hdr_ready_and_o),
    .data_i          (data_i),
    .data_v_i        (data_v_i),
    .data_ready_and_o(data_ready_and_o),
    .link_data_o     (link_data_o),
    .link_v_o        (link_v_o),
    .link_ready_and_i(link_ready_and_i)
  );

`ifdef BP_BURST_TO_WORMHOLE_HDR_BYPASS_EN
  localparam int byp_adj = 1;
`else
  localparam int byp_adj = 0;
`endif

  typedef struct {
    logic [47:0] pr_hdr;
    logic [3:0]  cord;
    int          n;
    int          stall_flit;  // link flit index at which link_ready drops (-1 none)
    int          stall_len;
    int          gap_beat;    // data beats already sent when data_v drops (-1 none)
    int          gap_len;
    logic [31:0] exp_f0;
    logic [31:0] exp_f1;
    int          exp_done;    // cycle index where hdr_ready returns, registered-header mode
  } vec_t;

  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_pkt(input int id);
    vec_t        v;
    logic [31:0] got[$];
    int          sent, stall, gap, done_t;
    bit          taken, done, prev_hold;
    logic [31:0] prev_data;
    v = vecs[id];
    sent = 0; stall = v.stall_len; gap = v.gap_len; done_t = -1;
    taken = 0; done = 0; prev_hold = 0; prev_data = '0;
    for (int t = 0; t < 80 && !done; t++) begin
      @(negedge clk_i);
      hdr_v_i      = !taken;
      pr_hdr_i     = v.pr_hdr;
      dst_cord_i   = v.cord;
      data_flits_i = 4'(v.n);
      link_ready_and_i = !(got.size() == v.stall_flit && stall > 0);
      if (!link_ready_and_i) stall--;
      if (sent == v.gap_beat && gap > 0 && sent < v.n) begin
        data_v_i = 1'b0;
        gap--;
      end else begin
        data_v_i = (sent < v.n);
      end
      data_i = 32'hD000_0000 + 32'(sent);
      #1;
      if (prev_hold) begin
        check32($sformatf("v%0d_hold_v", id), 32'(link_v_o), 32'd1);
        check32($sformatf("v%0d_hold_data", id), link_data_o, prev_data);
      end
      if (got.size() < 2)
        check32($sformatf("v%0d_no_data_in_hdr", id), 32'(data_ready_and_o), 32'd0);
      if (taken && got.size() == 2 + v.n && hdr_ready_and_o) begin
        done   = 1;
        done_t = t;
      end else begin
        prev_hold = link_v_o && !link_ready_and_i;
        prev_data = link_data_o;
        if (link_v_o && link_ready_and_i) got.push_back(link_data_o);
        if (data_v_i && data_ready_and_o) sent++;
        if (hdr_v_i && hdr_ready_and_o) taken = 1;
      end
    end
    hdr_v_i  = 1'b0;
    data_v_i = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL v%0d_timeout: got %0d flits expected %0d", id, got.size(), 2 + v.n);
    end else begin
      check32($sformatf("v%0d_done_cycle", id), 32'(done_t), 32'(v.exp_done - byp_adj));
    end
    check32($sformatf("v%0d_flit_count", id), 32'(got.size()), 32'(2 + v.n));
    if (got.size() > 0) check32($sformatf("v%0d_flit0", id), got[0], v.exp_f0);
    if (got.size() > 1) check32($sformatf("v%0d_flit1", id), got[1], v.exp_f1);
    for (int k = 0; k < v.n && k + 2 < got.size(); k++)
      check32($sformatf("v%0d_data%0d", id, k), got[k + 2], 32'hD000_0000 + 32'(k));
  endtask

  initial begin
    int cnt;
    bit taken;
    vecs[0] = '{48'h0123_4567_89AB, 4'h5,  0, -1, 0, -1, 0, 32'h6789_AB15, 32'h0001_2345,  3};
    vecs[1] = '{48'hFEDC_BA98_7654, 4'h3,  3, -1, 0, -1, 0, 32'h9876_5443, 32'h00FE_DCBA,  6};
    vecs[2] = '{48'hAAAA_5555_1234, 4'hA,  2,  1, 3, -1, 0, 32'h5512_343A, 32'h00AA_AA55,  8};
    vecs[3] = '{48'h0000_0000_0001, 4'hF,  4, -1, 0,  2, 2, 32'h0000_015F, 32'h0000_0000,  9};
    vecs[4] = '{48'hFFFF_FFFF_FFFF, 4'h0, 14, -1, 0, -1, 0, 32'hFFFF_FFF0, 32'h00FF_FFFF, 17};
    vecs[5] = '{48'h1357_9BDF_2468, 4'h9,  1,  2, 2, -1, 0, 32'hDF24_6829, 32'h0013_579B,  6};

    // Reset with every input requesting: nothing may handshake.
    reset_n_i = 1'b0;
    hdr_v_i = 1'b1; data_v_i = 1'b1; link_ready_and_i = 1'b1;
    pr_hdr_i = '0; dst_cord_i = '0; data_flits_i = 4'd1; data_i = '0;
    repeat (2) @(negedge clk_i);
    check32("rst_hdr_ready", 32'(hdr_ready_and_o), 32'd0);
    check32("rst_link_v", 32'(link_v_o), 32'd0);
    check32("rst_data_ready", 32'(data_ready_and_o), 32'd0);
    reset_n_i = 1'b1;
    #1;
    check32("rel_hdr_ready_late", 32'(hdr_ready_and_o), 32'd0);
    hdr_v_i = 1'b0; data_v_i = 1'b0;
    @(posedge clk_i); #1;
    check32("rel_hdr_ready_next", 32'(hdr_ready_and_o), 32'd1);

    for (int i = 0; i < 6; i++) send_pkt(i);

    // Abort a 5-flit packet after its 2nd flit with an asynchronous reset.
    cnt = 0; taken = 0;
    for (int t = 0; t < 20 && cnt < 2; t++) begin
      @(negedge clk_i);
      hdr_v_i = !taken; pr_hdr_i = vecs[1].pr_hdr; dst_cord_i = vecs[1].cord;
      data_flits_i = 4'd3; link_ready_and_i = 1'b1; data_v_i = 1'b1; data_i = 32'hBAD0_0000;
      #1;
      if (link_v_o && link_ready_and_i) cnt++;
      if (hdr_v_i && hdr_ready_and_o) taken = 1;
    end
    check32("abort_reached", 32'(cnt), 32'd2);
    @(negedge clk_i);
    hdr_v_i = 1'b0;
    #1;
    check32("abort_pre_link_v", 32'(link_v_o), 32'd1);
    reset_n_i = 1'b0;
    #1;
    check32("abort_link_v", 32'(link_v_o), 32'd0);
    check32("abort_data_ready", 32'(data_ready_and_o), 32'd0);
    check32("abort_hdr_ready", 32'(hdr_ready_and_o), 32'd0);
    @(negedge clk_i);
    data_v_i = 1'b0;
    reset_n_i = 1'b1;
    #1;
    check32("abort_rel_hdr_ready", 32'(hdr_ready_and_o), 32'd0);
    send_pkt(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
